acc_addr_datapath: RTL and testbench

- Accumulator-side datapath of the 8-bit microcomputer.
- Contains the 8-bit accumulator (AC), the 4-bit address register (AR), the E (extend/carry) flag, and the combinational adder/logic unit.
- The control unit drives one-hot register and ALU strobes. The common bus supplies bus_in. AC feeds the bus mux and AR addresses the RAM.

---
 rtl/acc_dp_pkg.sv | 38 +++
 rtl/acc_adder_logic.sv | 41 ++++
 rtl/acc_addr_datapath.sv | 91 +++++++++
 tb/tb_acc_addr_datapath.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_dp_pkg.sv
// Shared constants, ALU operation encoding and strobe priority encoder
// for the accumulator/address datapath.
package acc_dp_pkg;

    localparam int unsigned DEF_AC_W = 8;
    localparam int unsigned DEF_AR_W = 4;

    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_AND  = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_LDA  = 3'd3,
        ALU_CMA  = 3'd4,
        ALU_CIR  = 3'd5,
        ALU_CIL  = 3'd6
    } alu_op_e;

    // Collapse the nominally one-hot strobes; overlaps resolve AND>ADD>LDA>CMA>CIR>CIL.
    function automatic alu_op_e encode_alu_op(
        input logic op_and,
        input logic op_add,
        input logic op_lda,
        input logic op_cma,
        input logic op_cir,
        input logic op_cil
    );
        alu_op_e op;
        op = ALU_NONE;
        if (op_and)      op = ALU_AND;
        else if (op_add) op = ALU_ADD;
        else if (op_lda) op = ALU_LDA;
        else if (op_cma) op = ALU_CMA;
        else if (op_cir) op = ALU_CIR;
        else if (op_cil) op = ALU_CIL;
        return op;
    endfunction

endpackage

// File: rtl/acc_adder_logic.sv
// Combinational adder/logic unit: produces the next AC candidate and the
// adder carry-out from ac, dr, e and cin.
module acc_adder_logic
    import acc_dp_pkg::*;
#(
    parameter int unsigned AC_W = DEF_AC_W
) (
    input  logic [AC_W-1:0] ac,
    input  logic [AC_W-1:0] dr,
    input  logic            e,
    input  logic            cin,
    input  alu_op_e         alu_op,
    output logic [AC_W-1:0] alu_out,
    output logic            cout
);

    localparam int unsigned SUM_W = AC_W + 1;

    logic [AC_W:0] sum;

    assign sum = SUM_W'(ac) + SUM_W'(dr) + SUM_W'(cin);

    // Idle default passes ac through so the AC load path is harmless when unused.
    always_comb begin
        alu_out = ac;
        cout    = 1'b0;
        case (alu_op)
            ALU_AND: alu_out = ac & dr;
            ALU_ADD: begin
                alu_out = sum[AC_W-1:0];
                cout    = sum[AC_W];
            end
            ALU_LDA: alu_out = dr;
            ALU_CMA: alu_out = ~ac;
            ALU_CIR: alu_out = {e, ac[AC_W-1:1]};
            ALU_CIL: alu_out = {ac[AC_W-2:0], e};
            default: alu_out = ac;
        endcase
    end

endmodule

// File: rtl/acc_addr_datapath.sv
// Accumulator-side datapath: AC, AR and E registers around the adder/logic unit.
// Optional build macro ACC_ZERO_FLAG_EN adds the combinational ac_zero output.
module acc_addr_datapath
    import acc_dp_pkg::*;
#(
    parameter int unsigned AC_W = DEF_AC_W,
    parameter int unsigned AR_W = DEF_AR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AC_W-1:0] bus_in,
    input  logic [AC_W-1:0] dr,
    input  logic            cin,
    input  logic            ld_ac,
    input  logic            clr_ac,
    input  logic            inr_ac,
    input  logic            ld_ar,
    input  logic            clr_ar,
    input  logic            inr_ar,
    input  logic            op_and,
    input  logic            op_add,
    input  logic            op_lda,
    input  logic            op_cma,
    input  logic            op_cir,
    input  logic            op_cil,
`ifdef ACC_ZERO_FLAG_EN
    output logic            ac_zero,
`endif
    output logic [AC_W-1:0] ac,
    output logic [AR_W-1:0] ar,
    output logic            e,
    output logic [AC_W-1:0] alu_out,
    output logic            cout
);

    alu_op_e alu_op;

    assign alu_op = encode_alu_op(op_and, op_add, op_lda, op_cma, op_cir, op_cil);

    acc_adder_logic #(
        .AC_W (AC_W)
    ) u_adder_logic (
        .ac      (ac),
        .dr      (dr),
        .e       (e),
        .cin     (cin),
        .alu_op  (alu_op),
        .alu_out (alu_out),
        .cout    (cout)
    );

    // AC and E: clear beats ALU result beats bus load beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac <= '0;
            e  <= 1'b0;
        end else if (clr_ac) begin
            ac <= '0;
        end else if (alu_op != ALU_NONE) begin
            ac <= alu_out;
            case (alu_op)
                ALU_ADD: e <= cout;
                ALU_CIR: e <= ac[0];
                ALU_CIL: e <= ac[AC_W-1];
                default: e <= e;
            endcase
        end else if (ld_ac) begin
            ac <= bus_in;
        end else if (inr_ac) begin
            ac <= ac + AC_W'(1);
        end
    end

    // AR is loaded from the low bits of the bus and runs independently of AC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar <= '0;
        end else if (clr_ar) begin
            ar <= '0;
        end else if (ld_ar) begin
            ar <= bus_in[AR_W-1:0];
        end else if (inr_ar) begin
            ar <= ar + AR_W'(1);
        end
    end

`ifdef ACC_ZERO_FLAG_EN
    assign ac_zero = (ac == '0);
`endif

endmodule

// File: tb/tb_acc_addr_datapath.sv
// Scoreboard bench for acc_addr_datapath: stimulus queues expected values
// stamped with the cycle they become visible; a negedge monitor checks them.
module tb_acc_addr_datapath;

    localparam logic [5:0] M_AC   = 6'b000001;
    localparam logic [5:0] M_AR   = 6'b000010;
    localparam logic [5:0] M_E    = 6'b000100;
    localparam logic [5:0] M_ALU  = 6'b001000;
    localparam logic [5:0] M_COUT = 6'b010000;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_in;
    logic [7:0] dr;
    logic       cin;
    logic       ld_ac, clr_ac, inr_ac;
    logic       ld_ar, clr_ar, inr_ar;
    logic       op_and, op_add, op_lda, op_cma, op_cir, op_cil;
    logic [7:0] ac;
    logic [3:0] ar;
    logic       e;
    logic [7:0] alu_out;
    logic       cout;
`ifdef ACC_ZERO_FLAG_EN
    logic       ac_zero;
`endif

    acc_addr_datapath dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_in  (bus_in),
        .dr      (dr),
        .cin     (cin),
        .ld_ac   (ld_ac),
        .clr_ac  (clr_ac),
        .inr_ac  (inr_ac),
        .ld_ar   (ld_ar),
        .clr_ar  (clr_ar),
        .inr_ar  (inr_ar),
        .op_and  (op_and),
        .op_add  (op_add),
        .op_lda  (op_lda),
        .op_cma  (op_cma),
        .op_cir  (op_cir),
        .op_cil  (op_cil),
`ifdef ACC_ZERO_FLAG_EN
        .ac_zero (ac_zero),
`endif
        .ac      (ac),
        .ar      (ar),
        .e       (e),
        .alu_out (alu_out),
        .cout    (cout)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [5:0] mask;
        logic [7:0] ac;
        logic [3:0] ar;
        logic       e;
        logic [7:0] alu;
        logic       cout;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic void push(input int c, input string n, input logic [5:0] m,
                                 input logic [7:0] a, input logic [3:0] r, input logic ee,
                                 input logic [7:0] al, input logic co);
        exp_t x;
        x.cyc = c; x.name = n; x.mask = m; x.ac = a; x.ar = r; x.e = ee; x.alu = al; x.cout = co;
        sb.push_back(x);
    endfunction

    // Register results appear one cycle after the strobe; ALU results in the same cycle.
    function automatic void reg_exp(input string n, input logic [7:0] a, input logic ee);
        push(cyc + 1, n, M_AC | M_E, a, 4'h0, ee, 8'h00, 1'b0);
    endfunction
    function automatic void ar_exp(input string n, input logic [3:0] r);
        push(cyc + 1, n, M_AR, 8'h00, r, 1'b0, 8'h00, 1'b0);
    endfunction
    function automatic void alu_exp(input string n, input logic [7:0] al, input logic co);
        push(cyc, n, M_ALU | M_COUT, 8'h00, 4'h0, 1'b0, al, co);
    endfunction
    function automatic void rst_exp(input int c, input string n);
        push(c, n, M_AC | M_AR | M_E, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0);
    endfunction

    function automatic void cmp(input string n, input string f, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h (cycle %0d)", n, f, act, exp, cyc);
        end
    endfunction

    // Monitor: pop every entry due this cycle; anything older was missed.
    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            if (x.cyc < cyc) begin
                cmp(x.name, "missed_cycle", cyc, x.cyc);
            end else begin
                if (x.mask[0]) begin
                    cmp(x.name, "ac", int'(ac), int'(x.ac));
`ifdef ACC_ZERO_FLAG_EN
                    cmp(x.name, "ac_zero", int'(ac_zero), int'(x.ac == 8'h00));
`endif
                end
                if (x.mask[1]) cmp(x.name, "ar", int'(ar), int'(x.ar));
                if (x.mask[2]) cmp(x.name, "e", int'(e), int'(x.e));
                if (x.mask[3]) cmp(x.name, "alu_out", int'(alu_out), int'(x.alu));
                if (x.mask[4]) cmp(x.name, "cout", int'(cout), int'(x.cout));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
        {ld_ac, clr_ac, inr_ac, ld_ar, clr_ar, inr_ar} = '0;
        {op_and, op_add, op_lda, op_cma, op_cir, op_cil} = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_in = 8'h00; dr = 8'h00; cin = 1'b0;
        {ld_ac, clr_ac, inr_ac, ld_ar, clr_ar, inr_ar} = '0;
        {op_and, op_add, op_lda, op_cma, op_cir, op_cil} = '0;

        // Reset holds despite active strobes.
        next(); ld_ac = 1; ld_ar = 1; op_cma = 1; bus_in = 8'hAA;
        rst_exp(cyc, "reset_hold");
        next(); rst_n = 1'b1;

        next(); ld_ac = 1; bus_in = 8'h0C; reg_exp("ld_0c", 8'h0C, 1'b0);
        next(); op_and = 1; dr = 8'hFA;
        alu_exp("and", 8'h08, 1'b0); reg_exp("and", 8'h08, 1'b0);
        next(); op_add = 1; cin = 0;
        alu_exp("add_carry", 8'h02, 1'b1); reg_exp("add_carry", 8'h02, 1'b1);
        next(); op_cma = 1;
        alu_exp("cma", 8'hFD, 1'b0); reg_exp("cma", 8'hFD, 1'b1);
        next(); clr_ac = 1; reg_exp("clr_ac", 8'h00, 1'b1);
        next(); op_add = 1; dr = 8'h81;
        alu_exp("add_nocarry", 8'h81, 1'b0); reg_exp("add_nocarry", 8'h81, 1'b0);
        next(); op_cil = 1;
        alu_exp("cil", 8'h02, 1'b0); reg_exp("cil", 8'h02, 1'b1);
        next(); op_cir = 1;
        alu_exp("cir", 8'h81, 1'b0); reg_exp("cir", 8'h81, 1'b0);

        // Update-rule and ALU priority.
        next(); clr_ac = 1; op_lda = 1; ld_ac = 1; dr = 8'h26; bus_in = 8'h55;
        reg_exp("prio_clr", 8'h00, 1'b0);
        next(); op_lda = 1; ld_ac = 1;
        alu_exp("lda", 8'h26, 1'b0); reg_exp("prio_lda", 8'h26, 1'b0);
        next(); ld_ac = 1; bus_in = 8'h76; reg_exp("ld_76", 8'h76, 1'b0);
        next();
        alu_exp("no_op", 8'h76, 1'b0); reg_exp("hold", 8'h76, 1'b0);
        next(); op_and = 1; op_add = 1; dr = 8'h26; cin = 1;
        alu_exp("and_over_add", 8'h26, 1'b0); reg_exp("and_over_add", 8'h26, 1'b0);
        next(); op_add = 1; dr = 8'hD9; cin = 1;
        alu_exp("add_cin_wrap", 8'h00, 1'b1); reg_exp("add_cin_wrap", 8'h00, 1'b1);

        // Wrap boundaries and AR path.
        next(); ld_ac = 1; bus_in = 8'hFF; cin = 0; reg_exp("ld_ff", 8'hFF, 1'b1);
        next(); inr_ac = 1; reg_exp("inr_ac_wrap", 8'h00, 1'b1);
        next(); ld_ar = 1; bus_in = 8'h0F; ar_exp("ld_ar_f", 4'hF);
        next(); inr_ar = 1; ar_exp("inr_ar_wrap", 4'h0);
        next(); ld_ar = 1; inr_ac = 1; bus_in = 8'h9B;
        ar_exp("ld_ar_9b", 4'hB); reg_exp("inr_ac_par", 8'h01, 1'b1);
        next(); clr_ar = 1; ld_ar = 1; ar_exp("clr_over_ld_ar", 4'h0);
        next(); inr_ar = 1; ar_exp("inr_ar", 4'h1);

        // Asynchronous reset mid-cycle, then held across an edge.
        next(); ld_ac = 1; bus_in = 8'h5A; reg_exp("ld_5a", 8'h5A, 1'b1);
        next();
        next(); rst_n = 1'b0; ld_ac = 1; ld_ar = 1; bus_in = 8'h33;
        rst_exp(cyc, "async_reset"); rst_exp(cyc + 1, "reset_dominates");
        next(); rst_n = 1'b1;

        // Zero-crossing sequence.
        next(); ld_ac = 1; bus_in = 8'h01; reg_exp("ld_01", 8'h01, 1'b0);
        next(); ld_ac = 1; bus_in = 8'hFF; reg_exp("ld_ff2", 8'hFF, 1'b0);
        next(); inr_ac = 1; reg_exp("inr_to_zero", 8'h00, 1'b0);

        repeat (3) next();
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
